// File: rtl/adc_frame_capture_if.sv
// adc_frame_capture_if: valid/ready complex sample stream from the capture buffer to the receiver.
interface adc_frame_capture_if #(parameter int DATA_W = 14);
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    modport master (output out_real, out_imag, out_valid, out_last, input out_ready);
    modport slave  (input out_real, out_imag, out_valid, out_last, output out_ready);
endinterface

// File: rtl/adc_frame_capture.sv
// adc_frame_capture: ADC code conversion, energy trigger, single-frame capture and stream replay.
// Define ADC_OVERRANGE_EN to add the adc_or_a/adc_or_b inputs and the sticky frame_ovr output.
module adc_frame_capture #(
    parameter int DATA_W    = 14,
    parameter int FRAME_LEN = 64,
    parameter int HOLD_CNT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_real,
    input  logic [DATA_W-1:0] adc_imag,
    input  logic              adc_offset_bin,
    input  logic              arm,
    input  logic [DATA_W:0]   threshold,
`ifdef ADC_OVERRANGE_EN
    input  logic              adc_or_a,
    input  logic              adc_or_b,
    output logic              frame_ovr,
`endif
    adc_frame_capture_if.master s,
    output logic              busy,
    output logic              frame_done
);
    localparam int AW = $clog2(FRAME_LEN);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   re_q, re_d, im_q, im_d;
    logic [3:0]          hold_q, hold_d;
    logic [AW-1:0]       addr_q, addr_d, ra_q, ra_d, wa;
    logic                rd_vld_q, rd_vld_d;
    logic [2*DATA_W-1:0] rd_q, out_q, out_d;
    logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                frame_done_q, frame_done_d;
    logic [DATA_W:0]     re_x, im_x, energy;
    logic                trig, we, hs, load;
    logic [2*DATA_W-1:0] mem [FRAME_LEN];
    always_comb begin
        re_d = {adc_real[DATA_W-1] ^ adc_offset_bin, adc_real[DATA_W-2:0]};
        im_d = {adc_imag[DATA_W-1] ^ adc_offset_bin, adc_imag[DATA_W-2:0]};
        // One extra bit lets |-2^(DATA_W-1)| be represented exactly
        re_x = {re_q[DATA_W-1], re_q};
        im_x = {im_q[DATA_W-1], im_q};
        energy = (re_x[DATA_W] ? -re_x : re_x) + (im_x[DATA_W] ? -im_x : im_x);
        trig = state_q == ARMED && energy >= threshold && hold_q + 4'd1 == 4'(HOLD_CNT);
        we = trig || state_q == CAPTURE;
        wa = trig ? '0 : addr_q;
        hs = out_valid_q && s.out_ready;
        load = state_q == DRAIN && rd_vld_q && (!out_valid_q || (hs && !out_last_q));
        state_d = state_q;
        hold_d = 4'd0;
        addr_d = '0;
        case (state_q)
            IDLE: state_d = arm ? ARMED : IDLE;
            ARMED: begin
                hold_d = energy >= threshold ? hold_q + 4'd1 : 4'd0;
                if (trig) begin
                    state_d = CAPTURE;
                    addr_d = AW'(1);
                end
            end
            CAPTURE: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == AW'(FRAME_LEN - 1)) state_d = DRAIN;
            end
            default: if (hs && out_last_q) state_d = IDLE;
        endcase
        // ra tracks the address whose data sits in rd_q, so a load prefetches the next one
        ra_d = state_q == DRAIN ? ra_q + AW'(load) : '0;
        rd_vld_d = state_q == DRAIN && state_d == DRAIN;
        out_d = load ? rd_q : out_q;
        out_last_d = load ? (ra_q == AW'(FRAME_LEN - 1)) : (out_last_q && !hs);
        out_valid_d = load || (out_valid_q && !hs);
        frame_done_d = hs && out_last_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            re_q <= '0;
            im_q <= '0;
            hold_q <= '0;
            addr_q <= '0;
            ra_q <= '0;
            rd_vld_q <= 1'b0;
            out_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q <= re_d;
            im_q <= im_d;
            hold_q <= hold_d;
            addr_q <= addr_d;
            ra_q <= ra_d;
            rd_vld_q <= rd_vld_d;
            out_q <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= {re_q, im_q};
        rd_q <= mem[ra_d];
    end
`ifdef ADC_OVERRANGE_EN
    logic or_q, or_d, ovr_q, ovr_d;
    always_comb begin
        or_d = adc_or_a | adc_or_b;
        ovr_d = state_q != IDLE && (ovr_q || (we && or_q));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            or_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            or_q <= or_d;
            ovr_q <= ovr_d;
        end
    end
    assign frame_ovr = ovr_q;
`endif
    assign s.out_real = out_q[2*DATA_W-1:DATA_W];
    assign s.out_imag = out_q[DATA_W-1:0];
    assign s.out_valid = out_valid_q;
    assign s.out_last = out_last_q;
    assign busy = state_q != IDLE;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_adc_frame_capture.sv
// tb_adc_frame_capture: directed scoreboard bench for adc_frame_capture.
module tb_adc_frame_capture;
    localparam int DW = 14;
    localparam int FL = 64;
    localparam int HC = 4;
    localparam logic [DW-1:0] HALF = DW'(1 << (DW - 1));
    logic clk = 1'b0;
    logic reset, adc_offset_bin, arm, busy, frame_done;
    logic [DW-1:0] adc_real, adc_imag;
    logic [DW:0] threshold;
`ifdef ADC_OVERRANGE_EN
    logic adc_or_a, adc_or_b, frame_ovr;
`endif
    logic [2*DW:0] idle;
    logic [2*DW:0] stim_q[$];
    logic [2*DW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    adc_frame_capture_if #(.DATA_W(DW)) s ();
    adc_frame_capture #(.DATA_W(DW), .FRAME_LEN(FL), .HOLD_CNT(HC)) dut (
        .clk(clk), .reset(reset), .adc_real(adc_real), .adc_imag(adc_imag),
        .adc_offset_bin(adc_offset_bin), .arm(arm), .threshold(threshold),
`ifdef ADC_OVERRANGE_EN
        .adc_or_a(adc_or_a), .adc_or_b(adc_or_b), .frame_ovr(frame_ovr),
`endif
        .s(s), .busy(busy), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [DW-1:0] conv(input logic [DW-1:0] v);
        return adc_offset_bin ? v - HALF : v;
    endfunction
    function automatic int en(input logic [2*DW-1:0] c);
        int a, b;
        a = $signed(c[2*DW-1:DW]);
        b = $signed(c[DW-1:0]);
        return (a < 0 ? -a : a) + (b < 0 ? -b : b);
    endfunction
    task automatic push(input int re, input int im, input bit orb);
        stim_q.push_back({orb, DW'(re), DW'(im)});
    endtask
    task automatic push_ramp(input bit or30);
        stim_q.delete();
        repeat (3) push(-1, -1, 1'b0);
        for (int k = 0; k < FL + 8; k++) push(k, 200 + k, or30 && k == 30);
    endtask
    task automatic run_frame(input bit bp, input int abort_after, input bit chk_first,
                             input logic [2*DW-1:0] first_exp);
        int hold = 0, pushed = 0, acc = 0, cyc = 0, k = 0;
        bit done = 0, last_hs = 0, stall = 0, ovr = 0;
        logic [2*DW:0] x;
        logic [2*DW-1:0] c, e;
        logic [2*DW:0] held;
        adc_real = idle[2*DW-1:DW];
        adc_imag = idle[DW-1:0];
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        while (!done && cyc < 3000) begin
            if (abort_after > 0 && acc == abort_after) begin
                reset = 1'b1;
                s.out_ready = 1'b0;
                @(posedge clk); #1 reset = 1'b0;
                check("abort_valid", s.out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", frame_done, 0);
                @(posedge clk); #1;
                check("abort_done2", frame_done, 0);
                exp_q.delete();
                return;
            end
            x = stim_q.size() > 0 ? stim_q.pop_front() : idle;
            adc_real = x[2*DW-1:DW];
            adc_imag = x[DW-1:0];
`ifdef ADC_OVERRANGE_EN
            adc_or_a = 1'b0;
            adc_or_b = x[2*DW];
`endif
            c = {conv(x[2*DW-1:DW]), conv(x[DW-1:0])};
            if (pushed < FL) begin
                if (pushed == 0) hold = en(c) >= int'(threshold) ? hold + 1 : 0;
                if (pushed > 0 || hold == HC) begin
                    exp_q.push_back(c);
                    pushed++;
                    ovr = ovr | x[2*DW];
                end
            end
            s.out_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            k++;
            check("frame_done", frame_done, last_hs);
            if (last_hs) begin
                check("valid_after_last", s.out_valid, 0);
                check("busy_after_last", busy, 0);
                check("accepted_count", acc, FL);
                done = 1;
            end else begin
                if (stall) begin
                    check("stall_valid", s.out_valid, 1);
                    check("stall_data", {s.out_last, s.out_real, s.out_imag}, held);
                end
                stall = s.out_valid && !s.out_ready;
                held = {s.out_last, s.out_real, s.out_imag};
                if (s.out_valid && s.out_ready) begin
                    e = exp_q.size() > 0 ? exp_q.pop_front() : {2*DW{1'bx}};
                    check("data", {s.out_real, s.out_imag}, e);
                    if (acc == 0 && chk_first) check("first", {s.out_real, s.out_imag}, first_exp);
                    check("last", s.out_last, acc == FL - 1);
`ifdef ADC_OVERRANGE_EN
                    if (acc == FL - 1) check("frame_ovr", frame_ovr, ovr);
`endif
                    last_hs = acc == FL - 1;
                    acc++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("frame_complete", done, 1);
    endtask
    initial begin
        reset = 1'b1;
        arm = 1'b0;
        adc_offset_bin = 1'b0;
        threshold = '0;
        adc_real = '0;
        adc_imag = '0;
        s.out_ready = 1'b0;
        idle = '0;
`ifdef ADC_OVERRANGE_EN
        adc_or_a = 1'b0;
        adc_or_b = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", s.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_last", s.out_last, 0);
        check("rst_real", s.out_real, 0);
        check("rst_imag", s.out_imag, 0);
        reset = 1'b0;
        // offset-binary constant input, threshold 0
        adc_offset_bin = 1'b1;
        idle = {1'b0, 14'h2000, 14'h3FFF};
        stim_q.delete();
        repeat (FL + 16) stim_q.push_back(idle);
        run_frame(1'b0, 0, 1'b1, {14'h0000, 14'h1FFF});
        // trigger hold: the interrupted run must not count
        adc_offset_bin = 1'b0;
        threshold = 15'd1000;
        idle = '0;
        stim_q.delete();
        push(999, 0, 0); push(0, 1200, 0); push(1200, 0, 0); push(0, -1200, 0);
        push(500, 0, 0); push(600, 600, 0); push(1200, 0, 0); push(0, 1200, 0);
        push(700, 500, 0);
        for (int k = 0; k < FL + 8; k++) push(k, -k, 1'b0);
        run_frame(1'b0, 0, 1'b1, {14'd700, 14'd500});
        // backpressure 1,0,0,1 over a ramp
        threshold = 15'd1;
        push_ramp(1'b0);
        run_frame(1'b1, 0, 1'b1, {14'd0, 14'd200});
        // most negative code reaches exactly 8192
        threshold = 15'd8192;
        stim_q.delete();
        repeat (FL + 8) push(-8192, 0, 1'b0);
        run_frame(1'b0, 0, 1'b1, {14'h2000, 14'h0000});
        threshold = 15'd8193;
        idle = {1'b0, 14'h2000, 14'h0000};
        adc_real = 14'h2000;
        adc_imag = 14'h0000;
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (20) @(posedge clk);
            #1;
            check("no_trig_busy", busy, 1);
            check("no_trig_valid", s.out_valid, 0);
        end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("no_trig_reset_busy", busy, 0);
        // reset during drain, then a normal frame
        threshold = 15'd1;
        idle = '0;
        push_ramp(1'b0);
        run_frame(1'b0, 10, 1'b0, '0);
        push_ramp(1'b0);
        run_frame(1'b1, 0, 1'b1, {14'd0, 14'd200});
`ifdef ADC_OVERRANGE_EN
        push_ramp(1'b1);
        run_frame(1'b0, 0, 1'b1, {14'd0, 14'd200});
        push_ramp(1'b0);
        run_frame(1'b0, 0, 1'b1, {14'd0, 14'd200});
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adc_frame_capture.md
Name: adc_frame_capture

Overview:
- Receive-side front end between the dual-channel HSMC ADC pins (14-bit real on A, 14-bit imaginary on B) and the OFDM receiver core.
- Converts raw ADC codes to two's complement.
- Waits for an energy trigger, then stores one fixed-length frame of complex samples.
- Replays the frame to the receiver over a valid/ready stream.

Parameters:
- DATA_W, 14, ADC sample width per channel.
- FRAME_LEN, 64, samples captured per frame; power of two, 4..1024.
- HOLD_CNT, 4, consecutive above-threshold samples needed to trigger; 1..15.

Ports:
- clk  in  1  system clock; ADC data is synchronous to it.
- reset  in  1  synchronous, active-high.
- adc_real  in  DATA_W  channel A raw code.
- adc_imag  in  DATA_W  channel B raw code.
- adc_offset_bin  in  1  1 = raw codes are offset binary (DFS=0); 0 = already two's complement.
- arm  in  1  single-cycle request to start trigger search.
- threshold  in  DATA_W+1  unsigned energy threshold.
- out_real  out  DATA_W  signed sample, real.
- out_imag  out  DATA_W  signed sample, imaginary.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from receiver.
- out_last  out  1  marks sample FRAME_LEN-1.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after the last sample is accepted.

Behaviour:
- Reset is synchronous, active-high, on the single clock clk. On reset:
  - state goes to IDLE and the hold counter and address counter clear.
  - out_real, out_imag, out_valid, out_last, busy and frame_done are all 0.
- Stage S1 registers both channels each cycle.
  - When adc_offset_bin=1, the MSB is inverted, giving two's complement.
- Energy: E = |re| + |im| on S1, DATA_W+1 bits unsigned.
  - |-2^(DATA_W-1)| = 2^(DATA_W-1); no saturation is needed.
- Buffer: FRAME_LEN x 2*DATA_W RAM with a synchronous read.
- FSM:
  - IDLE: if arm=1, go to ARMED and clear the hold counter. arm in any other state is ignored.
  - ARMED: each cycle, if E >= threshold, increment the hold counter; otherwise clear it.
    - When the counter reaches HOLD_CNT, that S1 sample is written to address 0 and state goes to CAPTURE with addr=1.
  - CAPTURE: write S1 at addr every cycle and increment addr; the trigger is no longer evaluated.
    - After writing address FRAME_LEN-1, go to DRAIN.
  - DRAIN:
    - Read address 0 on entry; out_valid rises 2 cycles after DRAIN entry.
    - On each handshake (out_valid & out_ready), advance to the next sample. The next read is prefetched so the stream can sustain 1 sample/cycle.
    - While out_valid=1 and out_ready=0, out_real, out_imag and out_last hold stable.
    - out_last=1 exactly with sample FRAME_LEN-1.
    - On the handshake of the last sample: out_valid drops the next cycle, frame_done pulses that cycle, and state goes to IDLE.
- Timing and ordering:
  - ADC input to buffer write latency is 1 cycle.
  - Samples are stored in arrival order with no gaps; the ADC cannot be stalled.
- busy = (state != IDLE).
- Reset mid-operation: an ARMED/CAPTURE/DRAIN frame is abandoned.
  - out_valid drops in the cycle after reset is sampled.
  - No frame_done is generated.
- A threshold change takes effect on the next comparison.
- threshold = 0 triggers after HOLD_CNT cycles of any input.

Optional Feature:
- Macro ADC_OVERRANGE_EN.
- Defined:
  - Adds inputs adc_or_a and adc_or_b (1 bit each, registered with S1).
  - Adds output frame_ovr.
  - Any OR bit high on a sample written in ARMED-trigger or CAPTURE sets a sticky flag.
  - frame_ovr equals that flag and is valid while out_last=1; the flag clears when state returns to IDLE.
  - Samples themselves are stored unmodified.
- Undefined: no extra ports and no flag logic.

Test Plan:
- Offset-binary conversion:
  - Setup: adc_offset_bin=1, threshold=0, HOLD_CNT=4, arm.
  - Stimulus: adc_real=0x2000, adc_imag=0x3FFF constant.
  - Required response: 64 outputs, each re=0x0000 and im=0x1FFF; out_last on the 64th; one frame_done.
- Trigger hold:
  - Setup: two's complement input, threshold=1000.
  - Stimulus: energy 999,1200,1200,1200,500,1200,1200,1200,1200,ramp.
  - Required response: capture starts on the 9th sample; the first output equals the 9th sample.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeatedly.
  - Required response: data stable while stalled; the sequence is identical to the input ramp 0..63; no drop or duplicate.
- Negative extreme:
  - Stimulus: re=-8192, im=0, threshold=8192.
  - Required response: triggers. Stimulus: threshold=8193. Required response: never triggers; busy stays 1.
- Reset in DRAIN:
  - Stimulus: assert reset after 10 accepted samples.
  - Required response: next cycle out_valid=0, busy=0, no frame_done; a new arm captures normally.
- With ADC_OVERRANGE_EN:
  - Stimulus: adc_or_b pulse on capture sample 30.
  - Required response: frame_ovr=1 with out_last; next frame without OR gives frame_ovr=0.
